instruction_fetch: RTL and testbench

//   Front-end stage directly upstream of the instruction field decoder. Holds the PC and

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue.sv | 71 +++++++
 rtl/instruction_fetch.sv | 119 +++++++++++
 tb/tb_instruction_fetch.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int FETCH_ADDR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [FETCH_ADDR_W-1:0] pc;
  } fetch_entry_t;

  localparam int ENTRY_W = INSTR_W + FETCH_ADDR_W;
endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetched words with their PCs; synchronous flush drops all entries.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_entry,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [OCC_W-1:0]   occ
);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [OCC_W-1:0] occ_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Guard against popping empty / pushing full even if the caller misbehaves.
  always_comb begin
    do_pop_s  = pop && (occ_r != {OCC_W{1'b0}});
    do_push_s = push && ((occ_r != OCC_W'(DEPTH)) || do_pop_s);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      occ_r    <= {OCC_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      occ_r <= occ_r + OCC_W'(do_push_s) - OCC_W'(do_pop_s);
    end
  end

  // Entry storage, cleared to NOP on reset so the head is never undefined.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{instr: NOP_INSTR, pc: {FETCH_ADDR_W{1'b0}}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= fetch_entry_t'(push_entry);
    end
  end

  assign head = mem_r[rd_ptr_r];
  assign occ  = occ_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, issue/kill control and handoff to the decoder via fetch_queue.
// Optional FETCH_PERF_EN adds fetch_count / stall_count performance counters.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
`ifdef FETCH_PERF_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count,
`endif
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int CNT_W = OCC_W + 1;

  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  inflight_pc_r;
  logic               inflight_r;
  logic [ADDR_W-1:0]  redirect_target_s;
  logic [OCC_W-1:0]   occ_s;
  logic [CNT_W-1:0]   demand_s;
  logic               queue_nonempty_s;
  logic               pop_s;
  logic               push_s;
  logic               issue_s;
  logic [ENTRY_W-1:0] head_bits_s;
  logic [ENTRY_W-1:0] push_bits_s;
  fetch_entry_t       head_entry_s;
  fetch_entry_t       push_entry_s;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push_s),
    .push_entry (push_bits_s),
    .pop        (pop_s),
    .head       (head_bits_s),
    .occ        (occ_s)
  );

  // Handoff, issue and response-capture decisions for this cycle.
  always_comb begin
    queue_nonempty_s  = (occ_s != {OCC_W{1'b0}});
    instr_valid       = queue_nonempty_s && !redirect_valid && !reset;
    pop_s             = instr_valid && instr_ready;
    // Words already buffered plus the one in flight, minus the one leaving now.
    demand_s          = {1'b0, occ_s} + CNT_W'(inflight_r) - CNT_W'(pop_s);
    issue_s           = !reset && !redirect_valid && (demand_s < CNT_W'(DEPTH));
    // A response landing in a redirect cycle belongs to the old path and is dropped.
    push_s            = inflight_r && !redirect_valid && !reset;
    redirect_target_s = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
    push_entry_s.instr = imem_rdata;
    push_entry_s.pc    = FETCH_ADDR_W'(inflight_pc_r);
    push_bits_s        = push_entry_s;
    head_entry_s       = fetch_entry_t'(head_bits_s);
    imem_req           = issue_s;
    imem_addr          = pc_r;
    if (queue_nonempty_s) begin
      instruction = head_entry_s.instr;
      instr_pc    = ADDR_W'(head_entry_s.pc);
    end else begin
      instruction = NOP_INSTR;
      instr_pc    = {ADDR_W{1'b0}};
    end
  end

  // PC advance, redirect restart and in-flight tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      pc_r       <= redirect_target_s;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= pc_r;
        pc_r          <= pc_r + ADDR_W'(PC_STEP);
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Handoff and back-pressure counters; both wrap silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (pop_s) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (instr_valid && !instr_ready) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch; memory returns the address as data.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_req2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_valid2 = 1'b0;
  logic [31:0] redirect_pc2 = 32'h0000_0000;
  logic        instr_valid, instr_valid2;
  logic        instr_ready;
  logic        instr_ready2 = 1'b1;
  logic [31:0] instruction, instruction2;
  logic [31:0] instr_pc, instr_pc2;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .instr_pc(instr_pc)
  );

  instruction_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instruction(instruction2),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count2), .stall_count(stall_count2),
`endif
    .instr_pc(instr_pc2)
  );

  // Synchronous instruction memories: data = address, one cycle after the request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr;
    if (imem_req2) imem_rdata2 <= imem_addr2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expv(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, instr_pc, pc);
    chk({tag, "_instr"}, instruction, pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000;
    tick(); tick(); #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0000_0013);
    chk("rst_pc", instr_pc, 32'h0000_0000);

    // Reset release and streaming fetch
    tick(); reset = 1'b0; #1;
    chk("c0_req", {31'd0, imem_req}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0000_0000);
    chk("c0_addr2", imem_addr2, 32'hFFFF_FFF8);
    tick(); #1;
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    chk("c1_addr", imem_addr, 32'h0000_0004);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      expv("stream", 32'(4 * i));
      chk("wrap_valid", {31'd0, instr_valid2}, 32'd1);
      chk("wrap_pc", instr_pc2, 32'hFFFF_FFF8 + 32'(4 * i));
      chk("wrap_instr", instruction2, 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // Reset mid-run overrides handoff
    tick(); reset = 1'b1; #1;
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    tick(); reset = 1'b0; #1;
    chk("r2_addr", imem_addr, 32'h0000_0000);
    tick();
    tick(); #1; expv("r2_c2", 32'h0000_0000);
    tick(); #1; expv("r2_c3", 32'h0000_0004);

    // Back-pressure: 5 stalled cycles with 0x8 at the head
    tick(); instr_ready = 1'b0; #1;
    expv("stall_c4", 32'h0000_0008);
    chk("stall_c4_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      expv("stall_hold", 32'h0000_0008);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    tick(); instr_ready = 1'b1; #1;
    expv("resume_c9", 32'h0000_0008);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h0000_0010);
    tick(); #1; expv("resume_c10", 32'h0000_000C);
    tick(); #1; expv("resume_c11", 32'h0000_0010);

    // Redirect with a request in flight
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("redir_c13_req", {31'd0, imem_req}, 32'd1);
    chk("redir_c13_addr", imem_addr, 32'h0000_0100);
    chk("redir_c13_valid", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk("redir_c14_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_c14_addr", imem_addr, 32'h0000_0104);
    tick(); #1; expv("redir_tgt", 32'h0000_0100);

    // Redirect colliding with a ready handoff
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; #1;
    chk("coll_valid", {31'd0, instr_valid}, 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("coll_addr", imem_addr, 32'h0000_0200);
    chk("coll_c17_valid", {31'd0, instr_valid}, 32'd0);
    tick(); #1;
    chk("coll_c18_valid", {31'd0, instr_valid}, 32'd0);
    tick(); #1; expv("coll_tgt", 32'h0000_0200);

    // Back-to-back redirects: the last one wins, low bits ignored
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; #1;
    tick(); redirect_pc = 32'h0000_0406; #1;
    chk("b2b_valid", {31'd0, instr_valid}, 32'd0);
    tick(); redirect_valid = 1'b0; #1;
    chk("b2b_addr", imem_addr, 32'h0000_0404);
    tick();
    tick(); #1; expv("b2b_tgt", 32'h0000_0404);
    tick(); #1; expv("b2b_next", 32'h0000_0408);

    // Counter run: 10 handoffs, 3 stall cycles, then reset
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      expv("perf_run", 32'(4 * i));
    end
    tick(); instr_ready = 1'b0; #1; expv("perf_stall", 32'h0000_0028);
    tick(); #1; expv("perf_stall", 32'h0000_0028);
    tick(); #1; expv("perf_stall", 32'h0000_0028);
    tick(); reset = 1'b1; instr_ready = 1'b1; #1;
`ifdef FETCH_PERF_EN
    chk("fetch_count", fetch_count, 32'd10);
    chk("stall_count", stall_count, 32'd3);
`endif
    tick(); reset = 1'b0; #1;
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_instr", instruction, 32'h0000_0013);
    chk("post_rst_addr", imem_addr, 32'h0000_0000);
`ifdef FETCH_PERF_EN
    chk("fetch_count_clr", fetch_count, 32'd0);
    chk("stall_count_clr", stall_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
